contador_bcd_desc: RTL and testbench
====================================

CONTADOR_BCD_DESC -- requirements
Module: contador_bcd_desc

Interface
REQ-001 SHALL have parameter N, default 3, number of BCD digits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clk_en  input  1  count tick; one decrement per clk edge with clk_en=1 in RUN.
REQ-005 SHALL have port load  input  1  synchronous load strobe for din.
REQ-006 SHALL have port din  input  N*4  load value; digit i occupies bits [(i+1)*4-1:i*4], digit 0 least significant.
REQ-007 SHALL have port sal  output  N*4  current count, same digit packing as din.
REQ-008 SHALL have port fin  output  1  one-cycle terminal pulse.
REQ-009 SHALL have port activo  output  1  high while in RUN.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, FIN; all state, count and reload registers clocked on posedge clk.
REQ-011 SHALL, on load=1 in any state, write din to the count register and the reload register, clamping any digit >9 to 9.
REQ-012 SHALL, on load, enter RUN if the clamped value is nonzero, else enter IDLE with no fin pulse.
REQ-013 SHALL give load priority over clk_en: no decrement happens in a load cycle.
REQ-014 SHALL, in RUN with clk_en=1, decrement the count by one in BCD: digit i decrements when all digits below i are 0. A digit at 0 that receives a borrow wraps to 9.
REQ-015 SHALL, in RUN with clk_en=1 and count equal to 1, write count 0 and enter FIN.
REQ-016 SHALL hold count and state in RUN when clk_en=0.
REQ-017 SHALL ignore clk_en in IDLE and FIN.
REQ-018 SHALL drive fin=1 exactly while the FSM is in FIN; FIN lasts one cycle unless load intervenes.
REQ-019 SHALL drive activo=1 exactly while the FSM is in RUN.
REQ-020 SHALL drive sal directly from the count register, with no combinational path from inputs.
REQ-021 SHALL leave FIN on the next edge: to RUN when load=1 with a nonzero clamped din (REQ-012), otherwise per REQ-028/REQ-029.
REQ-022 SHALL never output a digit value >9.

Reset
REQ-023 SHALL, on rst=0, immediately force FSM=IDLE, count=0, reload=0.
REQ-024 SHALL, on rst=0, immediately force fin=0 and activo=0, independent of clk.
REQ-025 SHALL abort any count in progress when reset is asserted mid-RUN or in FIN, and SHALL produce no fin pulse.
REQ-026 SHALL resume normal operation on the first clk edge after rst returns to 1.

Configuration
REQ-027 SHALL support macro CONTADOR_BCD_DESC_AUTORELOAD_EN.
REQ-028 SHALL, with the macro defined, go FIN->RUN with count reloaded from the reload register; fin still pulses for one cycle. A reload value of 0 goes to IDLE instead.
REQ-029 SHALL, without the macro, go FIN->IDLE with count held at 0, and SHALL contain no reload-path logic beyond the load capture.

Verification
REQ-030 SHALL verify (N=3) load din=0x012, clk_en=1 every cycle -> sal 012,011,010,009,...,001,000; fin=1 for one cycle after the 12th tick; activo=1 for 12 cycles.
REQ-031 SHALL verify load din=0x100, one tick -> sal=0x099; another tick -> 0x098.
REQ-032 SHALL verify load din=0x0AF -> sal=0x099, activo=1; load din=0x000 -> IDLE, fin never asserts.
REQ-033 SHALL verify load and clk_en together at sal=0x005 with din=0x007 -> sal=0x007, no decrement; clk_en=0 for 10 cycles -> sal stays 0x007.
REQ-034 SHALL verify rst=0 asserted between edges mid-RUN at sal=0x003 -> sal=0, fin=0 and activo=0 before the next edge; no fin pulse after release.
REQ-035 SHALL verify, with the macro, load 0x002 and continuous ticks -> fin pulses every 3 cycles and sal cycles 002,001,000,002,...; without the macro -> a single fin pulse, then IDLE with sal=0.

Source files
------------

// File: rtl/contador_bcd_desc.sv
// contador_bcd_desc: N-digit BCD down-counter with load, run and terminal states.
// Loading din clamps each digit to 9 and starts a countdown if the value is nonzero.
// Each clk_en tick in RUN decrements the count by one. Reaching zero raises fin for one cycle.
// Optional feature: define CONTADOR_BCD_DESC_AUTORELOAD_EN to reload the captured value
// after each terminal pulse, so the count restarts automatically.
// Without that macro the FSM returns to IDLE after the terminal pulse.
// In that default build no reload copy is kept, because nothing would ever read it.
module contador_bcd_desc #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           load,
  input  logic [N*4-1:0] din,
  output logic [N*4-1:0] sal,
  output logic           fin,
  output logic           activo
);

  localparam int DW = N * 4;
  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t        state;
  logic [DW-1:0] count;
  logic [DW-1:0] din_clamped;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
  logic [DW-1:0] reload;
`endif

  // Saturate every digit above 9 down to 9 so no illegal BCD code enters the count.
  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < N; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Decrement by one in BCD: the borrow ripples up through zero digits, which wrap to 9.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Clamp the load value before it reaches the registers.
  always_comb begin
    din_clamped = bcd_clamp(din);
  end

  // FSM, count register and registered fin/activo flags.
  // Load always wins over a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
      reload <= '0;
`endif
      fin    <= 1'b0;
      activo <= 1'b0;
    end else if (load) begin
      count  <= din_clamped;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
      reload <= din_clamped;
`endif
      fin    <= 1'b0;
      if (din_clamped != '0) begin
        state  <= RUN;
        activo <= 1'b1;
      end else begin
        state  <= IDLE;
        activo <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        RUN: begin
          if (clk_en) begin
            if (count == ONE) begin
              count  <= '0;
              state  <= FIN;
              fin    <= 1'b1;
              activo <= 1'b0;
            end else begin
              count <= bcd_dec(count);
            end
          end
        end
        FIN: begin
          fin <= 1'b0;
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
          if (reload != '0) begin
            count  <= reload;
            state  <= RUN;
            activo <= 1'b1;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: begin
          state  <= IDLE;
          fin    <= 1'b0;
          activo <= 1'b0;
        end
      endcase
    end
  end

  assign sal = count;

endmodule

// File: tb/tb_contador_bcd_desc.sv
// Bench for contador_bcd_desc.
// The reference model keeps the count as a plain decimal integer.
// It is compared against the packed BCD output after every clock edge.
module tb_contador_bcd_desc;

  localparam int N  = 3;
  localparam int DW = N * 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_FIN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          load;
  logic [DW-1:0] din;
  logic [DW-1:0] sal;
  logic          fin;
  logic          activo;

  int n_chk  = 0;
  int n_pass = 0;
  int m_cnt  = 0;
  int m_rld  = 0;
  int m_st   = S_IDLE;
  int fins;

  contador_bcd_desc #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .load   (load),
    .din    (din),
    .sal    (sal),
    .fin    (fin),
    .activo (activo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  function automatic int clamp_val(input logic [DW-1:0] d);
    int v = 0;
    int p = 1;
    for (int i = 0; i < N; i++) begin
      int x;
      x = int'(d[i*4 +: 4]);
      if (x > 9) x = 9;
      v += x * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] to_bcd(input int v);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input logic e, input logic l, input logic [DW-1:0] d);
    if (l) begin
      m_cnt = clamp_val(d);
      m_rld = m_cnt;
      m_st  = (m_cnt != 0) ? S_RUN : S_IDLE;
    end else if (m_st == S_RUN) begin
      if (e) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = S_FIN;
      end
    end else if (m_st == S_FIN) begin
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
      if (m_rld != 0) begin
        m_cnt = m_rld;
        m_st  = S_RUN;
      end else begin
        m_st = S_IDLE;
      end
`else
      m_st = S_IDLE;
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".sal"}, 32'(sal), 32'(to_bcd(m_cnt)));
    chk({tag, ".fin"}, 32'(fin), 32'(m_st == S_FIN));
    chk({tag, ".activo"}, 32'(activo), 32'(m_st == S_RUN));
  endtask

  // One clock: drive inputs, take the edge, advance model, compare.
  task automatic tick(input string tag, input logic e, input logic l, input logic [DW-1:0] d);
    clk_en = e;
    load   = l;
    din    = d;
    @(posedge clk);
    #1;
    model_step(e, l, d);
    check_outputs(tag);
    if (fin) fins++;
  endtask

  // Async reset pulse placed between edges; called just after an edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b0;
    m_cnt = 0;
    m_rld = 0;
    m_st  = S_IDLE;
    #1;
    chk({tag, ".sal"}, 32'(sal), 32'h0);
    chk({tag, ".fin"}, 32'(fin), 32'h0);
    chk({tag, ".activo"}, 32'(activo), 32'h0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clk_en = 1'b0;
    load = 1'b0;
    din = '0;
    #2;
    chk("reset.sal", 32'(sal), 32'h0);
    chk("reset.fin", 32'(fin), 32'h0);
    chk("reset.activo", 32'(activo), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Full countdown from 12.
    fins = 0;
    tick("ld012", 1'b1, 1'b1, 12'h012);
    chk("ld012.const", 32'(sal), 32'h012);
    for (int i = 0; i < 12; i++) tick("cnt012", 1'b1, 1'b0, '0);
    chk("cnt012.end", 32'(sal), 32'h000);
    chk("cnt012.finpulse", 32'(fins), 32'd1);
    tick("after012", 1'b1, 1'b0, '0);

    // Borrow across two zero digits.
    tick("ld100", 1'b0, 1'b1, 12'h100);
    tick("t100a", 1'b1, 1'b0, '0);
    chk("t100a.const", 32'(sal), 32'h099);
    tick("t100b", 1'b1, 1'b0, '0);
    chk("t100b.const", 32'(sal), 32'h098);

    // Digit clamping and loading zero.
    tick("ld0af", 1'b0, 1'b1, 12'h0AF);
    chk("ld0af.const", 32'(sal), 32'h099);
    chk("ld0af.activo", 32'(activo), 32'h1);
    fins = 0;
    tick("ld000", 1'b1, 1'b1, 12'h000);
    for (int i = 0; i < 4; i++) tick("idle000", 1'b1, 1'b0, '0);
    chk("ld000.nofin", 32'(fins), 32'd0);

    // Load beats tick, then hold with clk_en low.
    tick("ld009", 1'b0, 1'b1, 12'h009);
    for (int i = 0; i < 4; i++) tick("to005", 1'b1, 1'b0, '0);
    chk("to005.const", 32'(sal), 32'h005);
    tick("ldtick007", 1'b1, 1'b1, 12'h007);
    chk("ldtick007.const", 32'(sal), 32'h007);
    for (int i = 0; i < 10; i++) tick("hold007", 1'b0, 1'b0, '0);
    chk("hold007.const", 32'(sal), 32'h007);

    // Asynchronous reset mid-run.
    tick("ld005", 1'b0, 1'b1, 12'h005);
    tick("to003a", 1'b1, 1'b0, '0);
    tick("to003b", 1'b1, 1'b0, '0);
    chk("to003.const", 32'(sal), 32'h003);
    async_reset("rstrun");
    fins = 0;
    for (int i = 0; i < 6; i++) tick("postrst", 1'b1, 1'b0, '0);
    chk("postrst.nofin", 32'(fins), 32'd0);

    // Terminal behaviour with and without auto-reload.
    fins = 0;
    tick("ld002", 1'b1, 1'b1, 12'h002);
    for (int i = 0; i < 9; i++) tick("run002", 1'b1, 1'b0, '0);
`ifdef CONTADOR_BCD_DESC_AUTORELOAD_EN
    chk("run002.fins", 32'(fins), 32'd3);
`else
    chk("run002.fins", 32'(fins), 32'd1);
    chk("run002.sal", 32'(sal), 32'h000);
`endif

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      logic          e;
      logic          l;
      logic [DW-1:0] d;
      e = ($urandom % 4) != 0;
      l = ($urandom % 12) == 0;
      if ($urandom % 2 == 0) d = to_bcd(int'($urandom_range(0, 6)));
      else d = DW'($urandom);
      tick("rand", e, l, d);
      if ($urandom % 60 == 0) async_reset("randrst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
